// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
//
// One prescaled countdown timer shared round-robin among N_REQ requesters.
// A requester raises req[i]; when the timer is free the next requester after
// the last owner (rotating priority) is granted, its duration dur[i] (in
// prescaled ticks) is loaded, and after the count expires done[i] pulses for
// one cycle while grant[i] is still high. Dropping req[owner] mid-count aborts
// the interval with no done pulse.
//
// Optional feature (macro TIMER_PAUSE_EN): adds input 'pause', which freezes
// the prescaler and the remaining count while the timer is running.
//
// Ports:
//   clk        system clock, rising edge
//   n_reset    synchronous active-low reset
//   req        [N_REQ]         level request per requester
//   dur        [N_REQ*CNT_W]   per-requester duration, requester i at [i*CNT_W +: CNT_W]
//   pause      (TIMER_PAUSE_EN only) hold the running count
//   grant      [N_REQ]         one-hot current owner, zero when idle
//   busy       timer owned (RUN or DONE)
//   done       [N_REQ]         one-cycle completion pulse to the owner
//   remaining  [CNT_W]         ticks left for the current owner, zero when idle
// -----------------------------------------------------------------------------
module timer_arbiter #(
    parameter int N_REQ    = 3,
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 50
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] dur,
`ifdef TIMER_PAUSE_EN
    input  logic                   pause,
`endif
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [N_REQ-1:0]       done,
    output logic [CNT_W-1:0]       remaining
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(N_REQ - 1);
    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [N_REQ-1:0] GRANT_LSB = N_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_reg;
    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  owner_reg;
    logic [PS_W-1:0]   prescaler_reg;
    logic [CNT_W-1:0]  remaining_reg;
    logic [N_REQ-1:0]  grant_reg;
    logic [N_REQ-1:0]  done_reg;

    // Unpack the flat duration bus into one entry per requester.
    logic [CNT_W-1:0]  dur_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dur
            assign dur_arr[gi] = dur[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // Rotating-priority winner: the first set req bit at ptr+1, ptr+2, ...
    // The loop runs from the farthest offset down to the nearest so the
    // nearest set bit is the last (and therefore final) assignment.
    logic              win_valid_next;
    logic [PTR_W-1:0]  win_idx_next;
    logic [PTR_W-1:0]  cand_idx;

    always_comb begin
        win_valid_next = 1'b0;
        win_idx_next   = ptr_reg;
        cand_idx       = ptr_reg;
        for (int k = N_REQ; k >= 1; k--) begin
            cand_idx = PTR_W'((int'(ptr_reg) + k) % N_REQ);
            if (req[cand_idx]) begin
                win_valid_next = 1'b1;
                win_idx_next   = cand_idx;
            end
        end
    end

    // Whether the running count may advance this cycle.
    logic run_en;
`ifdef TIMER_PAUSE_EN
    assign run_en = ~pause;
`else
    assign run_en = 1'b1;
`endif

    logic tick;
    assign tick = (prescaler_reg == PS_LAST);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= PTR_RESET;
            owner_reg     <= '0;
            prescaler_reg <= '0;
            remaining_reg <= '0;
            grant_reg     <= '0;
            done_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_valid_next) begin
                        owner_reg     <= win_idx_next;
                        remaining_reg <= dur_arr[win_idx_next];
                        prescaler_reg <= '0;
                        grant_reg     <= GRANT_LSB << win_idx_next;
                        state_reg     <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (!req[owner_reg]) begin
                        // Owner withdrew: release the timer silently.
                        ptr_reg       <= owner_reg;
                        remaining_reg <= '0;
                        prescaler_reg <= '0;
                        grant_reg     <= '0;
                        state_reg     <= ST_IDLE;
                    end else if (run_en) begin
                        if (remaining_reg == '0) begin
                            // Zero-length interval completes without a tick.
                            done_reg  <= grant_reg;
                            state_reg <= ST_DONE;
                        end else begin
                            prescaler_reg <= tick ? '0 : prescaler_reg + PS_W'(1);
                            if (tick) begin
                                remaining_reg <= remaining_reg - CNT_W'(1);
                                if (remaining_reg == CNT_W'(1)) begin
                                    done_reg  <= grant_reg;
                                    state_reg <= ST_DONE;
                                end
                            end
                        end
                    end
                end

                ST_DONE: begin
                    ptr_reg   <= owner_reg;
                    grant_reg <= '0;
                    done_reg  <= '0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= '0;
                    done_reg  <= '0;
                end
            endcase
        end
    end

    assign grant     = grant_reg;
    assign done      = done_reg;
    assign busy      = |grant_reg;
    assign remaining = remaining_reg;

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shared-interval timer controller for the bottling line.
- A single prescaled countdown timer is shared among N_REQ requesters, e.g. fill valve, capper and conveyor stop.
- Arbitration is round-robin. The block grants the timer to one requester, counts that requester's duration in prescaled ticks, then pulses done.
- This replaces per-station ripple dividers with one synchronous clock-enable timebase.

Parameters:
- N_REQ, 3: number of requesters.
- CNT_W, 8: width of each duration and of the remaining-count register.
- PRESCALE, 50: clk cycles per timer tick. Must be at least 1.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- n_reset, input, 1: synchronous, active-low reset.
- req, input, N_REQ: level request per requester. Held high until done or abort.
- dur, input, N_REQ*CNT_W: per-requester duration in ticks. Requester i uses bits [i*CNT_W +: CNT_W].
- grant, output, N_REQ: one-hot owner of the timer. All zeros when idle.
- busy, output, 1: high in RUN and DONE.
- done, output, N_REQ: one-cycle completion pulse to the owner.
- remaining, output, CNT_W: ticks left for the current owner. 0 when idle.

Behaviour:
- Reset (n_reset low at a clk edge):
  - state=IDLE; grant=0, done=0, busy=0, remaining=0.
  - prescaler=0; round-robin pointer ptr=N_REQ-1, so requester 0 wins first.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching ptr+1, ptr+2, … modulo N_REQ.
  - Register owner=winner, remaining=dur[winner], prescaler=0, go to RUN.
  - grant[owner] is asserted from the next cycle.
  - If no req bit is high, stay in IDLE.
- RUN:
  - Each cycle the prescaler increments. When it equals PRESCALE-1 it wraps to 0 and produces a tick.
  - On a tick with remaining>1: remaining decrements.
  - On a tick with remaining==1: remaining becomes 0 and the state goes to DONE.
  - If remaining==0 on the first RUN cycle (dur=0): go to DONE on the next edge, with no tick needed.
  - dur is sampled only in IDLE. Later changes to dur are ignored.
- DONE:
  - done[owner]=1 and grant[owner] stays 1 for exactly one cycle.
  - Next state is IDLE; ptr=owner.
- Abort:
  - If req[owner] goes low during RUN, the next state is IDLE.
  - No done pulse is produced. ptr=owner; remaining=0, prescaler=0.
- Requests in DONE:
  - A req still high in DONE is not aborted.
  - If it is still high in IDLE, it re-competes with lowest priority.
- Latency (request seen in IDLE at cycle T0, no abort):
  - done is high in cycle T0 + max(dur*PRESCALE, 1) + 1.
  - Example: dur=1, PRESCALE=4 gives done at T0+5.
- Simultaneous requests: exactly one grant. Losers wait without losing their request; fairness is strict rotation.
- Invariants:
  - grant and done are always one-hot or zero, and done is a subset of grant.
  - busy = grant != 0.
- Mid-operation reset: n_reset low in any state returns to reset values on that edge. No done pulse is emitted.
- PRESCALE=1: every RUN cycle is a tick.
- Arithmetic: remaining is unsigned CNT_W bits and never wraps below 0. The prescaler is sized for values up to PRESCALE-1.

Optional Feature:
- Macro: TIMER_PAUSE_EN.
- Enabled:
  - Adds input port pause (1 bit).
  - While pause=1 in RUN, the prescaler and remaining hold, grant and busy stay high, and no tick occurs.
  - pause has no effect in IDLE or DONE.
  - Abort via req low still applies while paused.
- Disabled: the port is absent and the timer always advances in RUN.

Test Plan (PRESCALE=4, CNT_W=8, N_REQ=3 unless stated):
- Reset, single grant: release n_reset, then req=001, dur0=3 -> grant=001 one cycle after the request; remaining 3→2→1 every 4 cycles; done=001 exactly 13 cycles after the IDLE sample cycle; then grant=000.
- Round-robin: req=111 held, all dur=1 -> grants in order 001, 010, 100, 001; each done pulse is one cycle wide; no two grant bits are ever high together.
- Zero duration: req=010, dur1=0 -> grant=010 for 2 cycles; done=010 in cycle T0+2; remaining stays 0.
- Abort: req=001, dur0=10; drop req0 after 9 cycles -> state returns to IDLE next edge; done never pulses; a pending req=100 is granted next.
- Reset mid-RUN: n_reset low during a count with remaining=5 -> grant=0, remaining=0, busy=0 on that edge; after release, req=011 grants requester 0 first.
- With TIMER_PAUSE_EN: dur0=2, pause=1 for 7 cycles mid-count -> done is delayed by exactly 7 cycles versus the unpaused run; remaining is frozen throughout the pause.
